// File: rtl/lfsr_checker_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_checker_pkg
// Shared definitions for the 22-bit PRBS generator and checker.
//   LFSR_W      : LFSR word width (22)
//   LFSR_SEED   : value of the first word of every sequence (22'd4)
//   lfsr_next() : one step of the x^22 + x^21 + 1 sequence
//   ST_*        : checker FSM state encoding
// -----------------------------------------------------------------------------
package lfsr_checker_pkg;

   localparam int LFSR_W = 22;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 22'd4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SYNC  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Shift left, feed back bit21 ^ bit20 into bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
      return {cur[LFSR_W-2:0], cur[LFSR_W-1] ^ cur[LFSR_W-2]};
   endfunction

endpackage

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Compares a stream of read-back words against the team PRBS sequence and
// reports mismatch statistics for one run of `length` words.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : single-cycle pulse, (re)starts a run; samples length
//   length              : number of words in the run
//   in_valid, in_data   : read-back word under test
//   busy, done          : run in progress / run complete (held until start)
//   error, error_count  : sticky mismatch flag, saturating mismatch count
//   word_count          : words accepted this run
//   first_err_*         : index, expected and actual word of the first mismatch
// Parameters:
//   ERRCNT_W       : error counter width
//   IDX_W          : word-index and length width
//   SYNC_ON_START  : 1 = first received word seeds the expected sequence
// -----------------------------------------------------------------------------
module lfsr_checker
   import lfsr_checker_pkg::*;
#(
   parameter int ERRCNT_W      = 16,
   parameter int IDX_W         = 24,
   parameter bit SYNC_ON_START = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [IDX_W-1:0]    length,
   input  logic                in_valid,
   input  logic [LFSR_W-1:0]   in_data,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [ERRCNT_W-1:0] error_count,
   output logic [IDX_W-1:0]    word_count,
   output logic [IDX_W-1:0]    first_err_index,
   output logic [LFSR_W-1:0]   first_err_expected,
   output logic [LFSR_W-1:0]   first_err_actual
);

   logic [1:0]        state;
   logic [1:0]        state_nxt;
   logic [LFSR_W-1:0] expected;
   logic [IDX_W-1:0]  len_q;
   logic [IDX_W-1:0]  count_next;
   logic              accept;
   logic              mismatch;

   assign count_next = word_count + 1'b1;
   assign mismatch   = (in_data != expected);

   // Next-state logic. start overrides everything (including a coincident
   // word, which is dropped); words are only accepted in SYNC and CHECK.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_nxt = state;
      accept    = 1'b0;
      if (start) begin
         if (length == '0)
            state_nxt = ST_DONE;
         else
            state_nxt = SYNC_ON_START ? ST_SYNC : ST_CHECK;
      end else if ((state == ST_SYNC || state == ST_CHECK) && in_valid) begin
         accept = 1'b1;
         if (count_next == len_q)
            state_nxt = ST_DONE;
         else
            state_nxt = ST_CHECK;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state              <= ST_IDLE;
         expected           <= LFSR_SEED;
         len_q              <= '0;
         busy               <= 1'b0;
         done               <= 1'b0;
         error              <= 1'b0;
         error_count        <= '0;
         word_count         <= '0;
         first_err_index    <= '0;
         first_err_expected <= '0;
         first_err_actual   <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == ST_SYNC) || (state_nxt == ST_CHECK);
         done  <= (state_nxt == ST_DONE);

         if (start) begin
            expected           <= LFSR_SEED;
            len_q              <= length;
            error              <= 1'b0;
            error_count        <= '0;
            word_count         <= '0;
            first_err_index    <= '0;
            first_err_expected <= '0;
            first_err_actual   <= '0;
         end else if (accept) begin
            word_count <= count_next;
            if (state == ST_SYNC) begin
               // Received word becomes the reference; it is never an error.
               expected <= lfsr_next(in_data);
            end else begin
               // Expected advances regardless of the compare (no resync).
               expected <= lfsr_next(expected);
               if (mismatch) begin
                  error <= 1'b1;
                  if (error_count != '1)
                     error_count <= error_count + 1'b1;
                  if (!error) begin
                     first_err_index    <= word_count;
                     first_err_expected <= expected;
                     first_err_actual   <= in_data;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_checker.sv
// -----------------------------------------------------------------------------
// tb_lfsr_checker
// Three checker instances share one stimulus stream:
//   u0 : default parameters
//   u1 : ERRCNT_W = 4 (saturation)
//   u2 : SYNC_ON_START = 1
// At each run start the reference model predicts each instance's final
// result and queues it; a monitor pops and compares when done is presented.
// -----------------------------------------------------------------------------
module tb_lfsr_checker;

   localparam int          IDX_W   = 24;
   localparam logic [21:0] SEED_TB = 22'h000004;

   typedef logic [21:0] word_q_t[$];

   typedef struct packed {
      logic        err;
      logic [15:0] cnt;
      logic [23:0] wc;
      logic [23:0] fidx;
      logic [21:0] fexp;
      logic [21:0] fact;
   } res_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [IDX_W-1:0]  length;
   logic              in_valid;
   logic [21:0]       in_data;

   logic [2:0]        busy_w;
   logic [2:0]        done_w;
   logic [2:0]        error_w;
   logic [15:0]       cnt0;
   logic [3:0]        cnt1;
   logic [15:0]       cnt2;
   logic [IDX_W-1:0]  wc   [3];
   logic [IDX_W-1:0]  fidx [3];
   logic [21:0]       fexp [3];
   logic [21:0]       fact [3];

   int n_tests = 0;
   int n_fail  = 0;

   res_t q0[$];
   res_t q1[$];
   res_t q2[$];

   always #5 clk = ~clk;

   lfsr_checker #(.ERRCNT_W(16), .IDX_W(IDX_W), .SYNC_ON_START(1'b0)) u0 (
      .clk(clk), .reset(reset), .start(start), .length(length),
      .in_valid(in_valid), .in_data(in_data),
      .busy(busy_w[0]), .done(done_w[0]), .error(error_w[0]), .error_count(cnt0),
      .word_count(wc[0]), .first_err_index(fidx[0]),
      .first_err_expected(fexp[0]), .first_err_actual(fact[0]));

   lfsr_checker #(.ERRCNT_W(4), .IDX_W(IDX_W), .SYNC_ON_START(1'b0)) u1 (
      .clk(clk), .reset(reset), .start(start), .length(length),
      .in_valid(in_valid), .in_data(in_data),
      .busy(busy_w[1]), .done(done_w[1]), .error(error_w[1]), .error_count(cnt1),
      .word_count(wc[1]), .first_err_index(fidx[1]),
      .first_err_expected(fexp[1]), .first_err_actual(fact[1]));

   lfsr_checker #(.ERRCNT_W(16), .IDX_W(IDX_W), .SYNC_ON_START(1'b1)) u2 (
      .clk(clk), .reset(reset), .start(start), .length(length),
      .in_valid(in_valid), .in_data(in_data),
      .busy(busy_w[2]), .done(done_w[2]), .error(error_w[2]), .error_count(cnt2),
      .word_count(wc[2]), .first_err_index(fidx[2]),
      .first_err_expected(fexp[2]), .first_err_actual(fact[2]));

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Sequence step from the polynomial x^22 + x^21 + 1, as integer arithmetic.
   function automatic logic [21:0] ref_step(input logic [21:0] cur);
      int unsigned v, fb;
      v  = cur;
      fb = ((v >> 21) ^ (v >> 20)) & 1;
      return 22'(((v * 2) % (1 << 22)) + fb);
   endfunction

   // Final result of a run of len words as seen by a checker instance.
   function automatic res_t model(input int len, input word_q_t w, input int errw, input bit sync);
      res_t        r;
      logic [21:0] e;
      int          maxc;
      r    = '0;
      e    = SEED_TB;
      maxc = (1 << errw) - 1;
      for (int i = 0; i < len; i++) begin
         if (sync && i == 0) begin
            e = ref_step(w[0]);
         end else begin
            if (w[i] !== e) begin
               if (!r.err) begin
                  r.fidx = 24'(i);
                  r.fexp = e;
                  r.fact = w[i];
               end
               r.err = 1'b1;
               if (int'(r.cnt) < maxc) r.cnt = r.cnt + 16'd1;
            end
            e = ref_step(e);
         end
      end
      r.wc = 24'(len);
      return r;
   endfunction

   // Reference sequence with roughly pct percent of words corrupted.
   function automatic word_q_t gen_words(input int n, input int pct);
      word_q_t     q;
      logic [21:0] e;
      e = SEED_TB;
      for (int i = 0; i < n; i++) begin
         if (int'($urandom_range(0, 99)) < pct) q.push_back(22'($urandom));
         else                                  q.push_back(e);
         e = ref_step(e);
      end
      return q;
   endfunction

   function automatic res_t actual(input int k);
      res_t r;
      r.err  = error_w[k];
      r.cnt  = (k == 0) ? cnt0 : (k == 1) ? {12'd0, cnt1} : cnt2;
      r.wc   = wc[k];
      r.fidx = fidx[k];
      r.fexp = fexp[k];
      r.fact = fact[k];
      return r;
   endfunction

   task automatic compare_res(input int k, input res_t e);
      res_t a;
      a = actual(k);
      check($sformatf("dut%0d error", k),           64'(a.err),  64'(e.err));
      check($sformatf("dut%0d error_count", k),     64'(a.cnt),  64'(e.cnt));
      check($sformatf("dut%0d word_count", k),      64'(a.wc),   64'(e.wc));
      check($sformatf("dut%0d first_err_index", k), 64'(a.fidx), 64'(e.fidx));
      check($sformatf("dut%0d first_err_exp", k),   64'(a.fexp), 64'(e.fexp));
      check($sformatf("dut%0d first_err_act", k),   64'(a.fact), 64'(e.fact));
      check($sformatf("dut%0d busy at done", k),    64'(busy_w[k]), 64'd0);
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < 3; k++) begin
         compare_res(k, '0);
         check($sformatf("%s dut%0d done", tag, k), 64'(done_w[k]), 64'd0);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic [2:0] done_prev  = 3'b000;
   logic       start_prev = 1'b0;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (done_w[k] && (!done_prev[k] || start_prev)) begin
            res_t e;
            bit   have;
            have = 1'b1;
            e    = '0;
            case (k)
               0:       if (q0.size() != 0) e = q0.pop_front(); else have = 1'b0;
               1:       if (q1.size() != 0) e = q1.pop_front(); else have = 1'b0;
               default: if (q2.size() != 0) e = q2.pop_front(); else have = 1'b0;
            endcase
            if (have) begin
               compare_res(k, e);
            end else begin
               n_tests++;
               n_fail++;
               $display("FAIL dut%0d unexpected done: got done=1, expected no pending run", k);
            end
         end
      end
      done_prev  = done_w;
      start_prev = start;
   end

   // ---------------------------------------------------------------- drivers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_gap(input int maxg);
      repeat ($urandom_range(0, maxg)) begin
         in_valid = 1'b0;
         in_data  = 22'($urandom);
         tick();
      end
   endtask

   task automatic send_word(input logic [21:0] w);
      in_valid = 1'b1;
      in_data  = w;
      tick();
      in_valid = 1'b0;
      in_data  = 22'($urandom);
   endtask

   task automatic start_run(input int len, input word_q_t w, input bit push, input bit with_valid);
      start    = 1'b1;
      length   = 24'(len);
      in_valid = with_valid;
      in_data  = 22'($urandom);
      if (push) begin
         q0.push_back(model(len, w, 16, 1'b0));
         q1.push_back(model(len, w, 4,  1'b0));
         q2.push_back(model(len, w, 16, 1'b1));
      end
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   // w holds len + extra words; words past len arrive after done and are ignored.
   task automatic do_run(input int len, input word_q_t w, input int extra);
      start_run(len, w, 1'b1, 1'b0);
      for (int i = 0; i < len + extra; i++) begin
         idle_gap(2);
         send_word(w[i]);
      end
      repeat (2) tick();
      check("dut0 word_count held after run", 64'(wc[0]), 64'(len));
      check("dut0 done held after run",       64'(done_w[0]), 64'd1);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      word_q_t w;
      word_q_t w2;
      int      len;
      int      extra;

      reset    = 1'b1;
      start    = 1'b0;
      length   = '0;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // Clean run of 20 words plus two ignored trailing words.
      tick();
      w = gen_words(22, 0);
      check("seq word 19", 64'(w[19]), 64'h200001);
      do_run(20, w, 2);

      // Single fault at word 5, with a latency check on error/error_count.
      w = gen_words(20, 0);
      w[5] = 22'h000000;
      start_run(20, w, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) check("error before fault word", 64'(error_w[0]), 64'd0);
         send_word(w[i]);
         if (i == 5) begin
            check("error one edge after fault",       64'(error_w[0]), 64'd1);
            check("error_count one edge after fault", 64'(cnt0), 64'd1);
         end
      end
      repeat (2) tick();

      // Randomized runs.
      for (int r = 0; r < 8; r++) begin
         len   = int'($urandom_range(1, 30));
         extra = int'($urandom_range(0, 2));
         w     = gen_words(len + extra, 25);
         do_run(len, w, extra);
      end

      // Saturation: 20 zero words.
      w = {};
      for (int i = 0; i < 20; i++) w.push_back(22'h0);
      do_run(20, w, 0);
      check("saturated error_count dut1", 64'(cnt1), 64'hF);

      // Sync mode.
      w = {22'h200001, 22'h000003, 22'h000006};
      do_run(3, w, 0);
      check("sync dut2 error",      64'(error_w[2]), 64'd0);
      check("sync dut2 word_count", 64'(wc[2]), 64'd3);

      // Zero length, twice back to back, then a length-1 run.
      w = {};
      do_run(0, w, 0);
      do_run(0, w, 0);
      w = gen_words(1, 50);
      do_run(1, w, 0);

      // Abort mid-CHECK with a coincident word, which must be dropped.
      w = gen_words(10, 0);
      w[1] = ~w[1];
      start_run(10, w, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_word(w[i]);
      check("error set before abort", 64'(error_w[0]), 64'd1);
      w2 = gen_words(5, 0);
      start_run(5, w2, 1'b1, 1'b1);
      check("abort word_count cleared", 64'(wc[0]), 64'd0);
      check("abort error cleared",      64'(error_w[0]), 64'd0);
      check("abort busy",               64'(busy_w[0]), 64'd1);
      for (int i = 0; i < 5; i++) send_word(w2[i]);
      repeat (2) tick();

      // Reset mid-run after an error; reset beats coincident start/in_valid.
      w = gen_words(10, 0);
      w[1] = ~w[1];
      start_run(10, w, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) send_word(w[i]);
      reset    = 1'b1;
      start    = 1'b1;
      length   = 24'd5;
      in_valid = 1'b1;
      tick();
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      check_all_zero("mid-run reset");
      for (int i = 0; i < 3; i++) send_word(SEED_TB);
      check("idle ignores words: word_count", 64'(wc[0]), 64'd0);
      check("idle ignores words: busy",       64'(busy_w[0]), 64'd0);

      repeat (5) tick();
      check("pending results dut0", 64'(q0.size()), 64'd0);
      check("pending results dut1", 64'(q1.size()), 64'd0);
      check("pending results dut2", 64'(q2.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule
